// File: rtl/lava_pattern_sequencer_if.sv
// ----------------------------------------------------------------------------
// lava_pattern_sequencer_if
//
// Purpose:
//    Bundles the run request and all pattern/status outputs of the lava
//    pattern sequencer into one connection.
//
// Signals:
//    start        run request from the game controller (level-sensitive)
//    pattern      12-bit parallel pattern for the downstream shift register
//    load_n       0 = downstream register loads pattern, 1 = it shifts left
//    shift_count  index of the current SHIFT cycle (0..10), 0 otherwise
//    level        difficulty level (0..15) for the HEX decoder
//    pattern_done one-cycle pulse in the final SHIFT cycle of each pattern
//    level_up     one-cycle pulse in the cycle after the level increments
//
// Modports:
//    master  side that issues start and consumes the outputs
//    slave   the sequencer itself
// ----------------------------------------------------------------------------
interface lava_pattern_sequencer_if;
   logic        start;
   logic [11:0] pattern;
   logic        load_n;
   logic [3:0]  shift_count;
   logic [3:0]  level;
   logic        pattern_done;
   logic        level_up;

   // Controller / observer view of the sequencer
   modport master (
      output start,
      input  pattern,
      input  load_n,
      input  shift_count,
      input  level,
      input  pattern_done,
      input  level_up
   );

   // Sequencer view: takes start, drives everything else
   modport slave (
      input  start,
      output pattern,
      output load_n,
      output shift_count,
      output level,
      output pattern_done,
      output level_up
   );
endinterface

// File: rtl/lava_pattern_sequencer.sv
// ----------------------------------------------------------------------------
// lava_pattern_sequencer
//
// Purpose:
//    Produces 12-bit lava-row patterns from a maximal-length 12-bit Fibonacci
//    LFSR and sequences the downstream 12-bit load/shift register: one LOAD
//    cycle followed by eleven SHIFT cycles per pattern, one cycle per screen
//    row step. Patterns are thinned (ANDed with their own rotation) while the
//    difficulty level is below DENSE_LEVEL. The level rises by one every
//    PATTERNS_PER_LEVEL completed patterns and saturates at 15.
//
// Ports:
//    clock    roll clock, rising-edge active
//    reset_n  asynchronous active-low reset
//    bus      slave side of lava_pattern_sequencer_if (start in, status out)
//
// Parameters:
//    SEED                LFSR reset value (0 is replaced by 12'h001)
//    PATTERNS_PER_LEVEL  completed patterns per level increment (1..15)
//    DENSE_LEVEL         level at or above which patterns are not thinned
// ----------------------------------------------------------------------------
module lava_pattern_sequencer #(
   parameter logic [11:0] SEED               = 12'hACE,
   parameter int          PATTERNS_PER_LEVEL = 8,
   parameter int          DENSE_LEVEL        = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   lava_pattern_sequencer_if.slave  bus
);

   // An all-zero LFSR would lock up, so a zero seed is bumped to 1.
   localparam logic [11:0] SEED_INIT  = (SEED == 12'h000) ? 12'h001 : SEED;
   localparam logic [3:0]  PPL_LAST   = 4'(PATTERNS_PER_LEVEL - 1);
   localparam logic [4:0]  DENSE_LVL  = 5'(DENSE_LEVEL);
   localparam logic [3:0]  LAST_SHIFT = 4'd10;
   localparam logic [3:0]  MAX_LEVEL  = 4'd15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] lfsr_q, lfsr_d;
   logic [3:0]  shift_count_q, shift_count_d;
   logic [3:0]  pattern_cnt_q, pattern_cnt_d;
   logic [3:0]  level_q, level_d;
   logic        level_up_q, level_up_d;

   logic [11:0] lfsr_next;
   logic [11:0] lfsr_thin;

   // Taps 12,11,10,4 give the maximal 4095-state sequence; shifting left
   // keeps the newest bit at the LSB.
   assign lfsr_next = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3]};

   // Thinning keeps a lava cell only if its right-hand neighbour (with
   // wrap-around) is also lava, which roughly halves the density.
   assign lfsr_thin = lfsr_q & {lfsr_q[0], lfsr_q[11:1]};

   // State register: every piece of sequencer state lives here and is
   // cleared the instant reset_n drops, independent of the roll clock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         lfsr_q        <= SEED_INIT;
         shift_count_q <= 4'd0;
         pattern_cnt_q <= 4'd0;
         level_q       <= 4'd0;
         level_up_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         shift_count_q <= shift_count_d;
         pattern_cnt_q <= pattern_cnt_d;
         level_q       <= level_d;
         level_up_q    <= level_up_d;
      end
   end

   // Next-state logic: IDLE waits for start, LOAD lasts exactly one cycle
   // and advances the LFSR, SHIFT runs eleven cycles and then decides
   // between another LOAD and IDLE. The pattern boundary is also where the
   // pattern counter and level are bumped, so a new level takes effect on
   // the very next LOAD.
   always_comb begin
      state_d       = state_q;
      lfsr_d        = lfsr_q;
      shift_count_d = shift_count_q;
      pattern_cnt_d = pattern_cnt_q;
      level_d       = level_q;
      level_up_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d       = SHIFT;
            lfsr_d        = lfsr_next;
            shift_count_d = 4'd0;
         end
         SHIFT: begin
            if (shift_count_q == LAST_SHIFT) begin
               shift_count_d = 4'd0;
               state_d       = bus.start ? LOAD : IDLE;
               if (pattern_cnt_q == PPL_LAST) begin
                  pattern_cnt_d = 4'd0;
                  if (level_q != MAX_LEVEL) begin
                     level_d    = level_q + 4'd1;
                     level_up_d = 1'b1;
                  end
               end else begin
                  pattern_cnt_d = pattern_cnt_q + 4'd1;
               end
            end else begin
               shift_count_d = shift_count_q + 4'd1;
            end
         end
         default: begin
            state_d       = IDLE;
            shift_count_d = 4'd0;
         end
      endcase
   end

   // Output decode: everything is a function of registered state only, so
   // start never reaches an output combinationally. IDLE presents zeros
   // with load_n low so the downstream register is flushed to empty.
   always_comb begin
      bus.pattern      = 12'h000;
      bus.load_n       = 1'b0;
      bus.pattern_done = 1'b0;
      if (state_q != IDLE) begin
         bus.pattern = ({1'b0, level_q} < DENSE_LVL) ? lfsr_thin : lfsr_q;
      end
      if (state_q == SHIFT) begin
         bus.load_n       = 1'b1;
         bus.pattern_done = (shift_count_q == LAST_SHIFT);
      end
      bus.shift_count = shift_count_q;
      bus.level       = level_q;
      bus.level_up    = level_up_q;
   end

endmodule

// File: doc/lava_pattern_sequencer.md
Name: lava_pattern_sequencer

Overview:
- Generates the 12-bit lava-row patterns for the downstream 12-bit load/shift register and drives that register's active-low load control (`load_n`: 0 = parallel load, 1 = shift left).
- Both blocks run on the same slowed screen-roll clock, so one clock cycle equals one screen row step.
- Patterns come from a maximal-length 12-bit LFSR. They are thinned at low difficulty levels.
- The block also keeps a difficulty level, which the HEX display decoder shows.

Parameters:
SEED, 12'hACE, LFSR reset value; a value of 0 is replaced by 12'h001.
PATTERNS_PER_LEVEL, 8, completed patterns per level increment (range 1..15).
DENSE_LEVEL, 4, level at or above which patterns are unthinned.

Ports:
clock  input  1  roll clock, rising-edge active
reset_n  input  1  asynchronous, active-low reset
start  input  1  run request (level-sensitive)
pattern  output  12  parallel pattern to the shift register's d input
load_n  output  1  0 = shift register loads pattern; 1 = shift register shifts
shift_count  output  4  index of the current SHIFT cycle (0..10); 0 outside SHIFT
level  output  4  difficulty level (0..15), to the HEX decoder
pattern_done  output  1  one-cycle pulse in the final SHIFT cycle of each pattern
level_up  output  1  one-cycle pulse in the cycle after level increments

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low (reset_n); all state is cleared immediately on reset_n=0.
- Reset values:
  - state = IDLE, lfsr = SEED (or 12'h001 if SEED = 0), pattern counter = 0.
  - level = 0, shift_count = 0, load_n = 0, pattern = 12'h000.
  - pattern_done = 0, level_up = 0.
- LFSR update: Fibonacci, shift left; next = {lfsr[10:0], lfsr[11]^lfsr[10]^lfsr[9]^lfsr[3]}. It never reaches 0.
- Pattern output:
  - IDLE: pattern = 0.
  - Otherwise, if level < DENSE_LEVEL: pattern = lfsr & {lfsr[0], lfsr[11:1]}.
  - Otherwise: pattern = lfsr.
- FSM states IDLE, LOAD, SHIFT:
  - IDLE: load_n = 0, so the downstream register holds zeros.
    - start = 1 at a rising edge -> LOAD.
    - Otherwise stay in IDLE.
  - LOAD: exactly one cycle; load_n = 0. The downstream register captures pattern at the edge that ends LOAD.
    - That same edge advances lfsr by one step.
    - Next state is always SHIFT, with shift_count = 0.
  - SHIFT: load_n = 1; shift_count increments 0..10 on each edge.
    - pattern_done = 1 while shift_count = 10.
    - On the edge leaving shift_count = 10: if start = 1 -> LOAD, else -> IDLE.
- Pattern period:
  - One pattern takes exactly 12 cycles: LOAD plus 11 SHIFT cycles.
  - Downstream MSB bits 11..0 appear on consecutive cycles; bit 0 is visible during the following LOAD or IDLE cycle.
- start deasserted mid-pattern: the current pattern completes. IDLE is entered only at the pattern boundary.
- Restart after IDLE: lfsr and level are retained; only reset_n reinitialises them.
- Pattern counter and level:
  - The pattern counter increments on the edge leaving shift_count = 10.
  - When it reaches PATTERNS_PER_LEVEL it wraps to 0 and level increments, saturating at 15.
  - level_up = 1 in the next cycle (the LOAD or IDLE cycle) only when level actually changed; there is no pulse at saturation.
  - The new level applies to the pattern loaded in that cycle.
- Registering: all outputs are registered or decoded purely from registered state. There are no combinational input-to-output paths.

Test Plan:
- Reset, then start = 1 from cycle 0 -> cycle 1 is LOAD with load_n = 0 and pattern = 12'h046 (12'hACE masked). load_n = 1 for cycles 2..12; pattern_done high in cycle 12; cycle 13 is LOAD with pattern = 12'h08C (12'h59D masked).
- Run 8 patterns with PATTERNS_PER_LEVEL = 8 -> level goes 0 -> 1 on the edge after the 8th pattern_done, with level_up high for exactly that one LOAD cycle. After 120 patterns level = 15 and stays there, with no further level_up pulses.
- Force level >= 4 (DENSE_LEVEL = 0 build) -> first pattern = 12'hACE, second = 12'h59D, third = 12'hB3A.
- Drop start at shift_count = 3 -> SHIFT continues through shift_count = 10, then IDLE with load_n = 0 and pattern = 0. Reassert start -> next LOAD shows the next LFSR value, not SEED.
- Assert reset_n = 0 mid-SHIFT, asynchronously and between edges -> outputs go immediately to reset values. After release with start = 1, the first LOAD pattern = 12'h046 again.
- SEED = 0 build -> lfsr initialises to 12'h001. Over 4095 patterns no lfsr state repeats and none is zero.
